intersection_scheduler: RTL

Two-approach intersection controller that shares one crossing between north-south (NS) traffic, east-west (EW) traffic and a pedestrian phase. It latches demand from vehicle sensors and a pedestrian button, alternates service fairly, and enforces minimum and maximum green, yellow, all-red clearance and walk durations. It also handles emergency preemption toward a selected direction. It drives all lamp outputs for the junction and sits directly above the per-signal lamp logic.

---
 rtl/intersection_pkg.sv | 17 +
 rtl/intersection_scheduler_phase_timer.sv | 29 ++
 rtl/intersection_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/intersection_pkg.sv
// Shared encodings for the intersection controller: phase/state codes and
// approach direction constants.
package intersection_pkg;

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } state_t;

    localparam logic NS = 1'b0;
    localparam logic EW = 1'b1;

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Phase duration counter: clear on phase change, optional hold, optional
// saturation, and an equality compare against the current phase limit.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             hold,
    input  logic             sat_en,
    input  logic [CNT_W-1:0] sat_val,
    input  logic [CNT_W-1:0] term_val,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!hold && !(sat_en && count >= sat_val)) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == term_val);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection controller with pedestrian phase and emergency
// preemption; lamps are decoded directly from the state register.
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    input  logic       emergency,
    input  logic       emerg_dir,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] MIN_END  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] MAX_END  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_END   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_END = CNT_W'(WALK_T - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, term_val;
    logic             term, hold, change, in_green;
    logic             ns_d, ew_d, ped_d, next_dir, pick;
    logic             ns_leave, ew_leave;

    assign change   = (state_nxt != state);
    assign in_green = (state == NS_GREEN) || (state == EW_GREEN);

    always_comb begin
        case (state)
            ALL_RED:              term_val = AR_END;
            NS_YELLOW, EW_YELLOW: term_val = YEL_END;
            PED_WALK:             term_val = WALK_END;
            default:              term_val = MAX_END;
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (change),
        .hold     (hold),
        .sat_en   (in_green),
        .sat_val  (MAX_END),
        .term_val (term_val),
        .count    (count),
        .term     (term)
    );

    // In green, term means the GREEN_MAX cap has been reached.
    assign ns_leave = (ew_d || ped_d) && ((count >= MIN_END && !ns_req) || term);
    assign ew_leave = (ns_d || ped_d) && ((count >= MIN_END && !ew_req) || term);

    always_comb begin
        pick = next_dir;
        if (emergency)
            pick = emerg_dir;
        else if (next_dir ? ew_d : ns_d)
            pick = next_dir;
        else if (next_dir ? ns_d : ew_d)
            pick = ~next_dir;
    end

    always_comb begin
        state_nxt = state;
        hold      = 1'b0;
        case (state)
            ALL_RED: begin
                if (term) begin
                    if (ped_d && !emergency)
                        state_nxt = PED_WALK;
                    else
                        state_nxt = pick ? EW_GREEN : NS_GREEN;
                end
            end
            NS_GREEN: begin
                if (emergency && emerg_dir == NS)
                    hold = 1'b1;
                else if (emergency || ns_leave)
                    state_nxt = NS_YELLOW;
            end
            EW_GREEN: begin
                if (emergency && emerg_dir == EW)
                    hold = 1'b1;
                else if (emergency || ew_leave)
                    state_nxt = EW_YELLOW;
            end
            NS_YELLOW, EW_YELLOW: begin
                if (term)
                    state_nxt = ALL_RED;
            end
            PED_WALK: begin
                if (term || emergency)
                    state_nxt = ALL_RED;
            end
            default: state_nxt = ALL_RED;
        endcase
    end

    // Demand latches clear on the entry edge; a request on that edge is absorbed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ALL_RED;
            ns_d     <= 1'b0;
            ew_d     <= 1'b0;
            ped_d    <= 1'b0;
            next_dir <= NS;
        end else begin
            state <= state_nxt;
            ns_d  <= (ns_d || ns_req) && !(change && state_nxt == NS_GREEN);
            ew_d  <= (ew_d || ew_req) && !(change && state_nxt == EW_GREEN);
            ped_d <= (ped_d || ped_req) && !(change && state_nxt == PED_WALK);
            if (change && state_nxt == NS_GREEN)
                next_dir <= EW;
            else if (change && state_nxt == EW_GREEN)
                next_dir <= NS;
        end
    end

    always_comb begin
        ns_red    = 1'b1;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b1;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        walk      = 1'b0;
        case (state)
            NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
            NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
            EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
            EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
            PED_WALK:  walk = 1'b1;
            default:   ;
        endcase
    end

    assign phase = state;

endmodule
